snake: RTL and testbench
========================

Name: snake

Overview:
- Grid-based snake-game position engine: holds the head coordinate, up to 5 trailing body segments, and the current heading.
- Advances one cell per `update` tick, with optional left/right rotation and growth.
- Sits between the game-tick/input logic (button debouncers, tick divider) and the renderer/collision logic, which consume `head` and `body` as flat buses.

Parameters:
- GRID_W, 64, grid width in cells; x ranges 0..GRID_W-1.
- GRID_H, 48, grid height in cells; y ranges 0..GRID_H-1.
- START_X, 32, head x after reset.
- START_Y, 24, head y after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- start  input  1  synchronous active-high reset; restarts the game state.
- update  input  1  move enable, sampled every rising edge; 1 = advance one cell this cycle.
- rotL  input  1  turn 90° counter-clockwise on this move.
- rotR  input  1  turn 90° clockwise on this move.
- grow  input  1  lengthen body by one segment on this move.
- head  output  40  head coordinate: [39:20] = x, [19:0] = y, both unsigned.
- body  output  200  5 segments × 40 bits; segment i = body[40i+39:40i] in the same x/y layout; segment 0 is adjacent to the head.

Behaviour:
- One clock domain. `start` is synchronous and active-high, and has priority over all other inputs.
- Internal state:
  - head x/y, 20 bits each;
  - 5 body segment registers, 40 bits each;
  - len, 3 bits, range 0..5, counting valid segments;
  - dir, 2 bits: 0 = RIGHT (+x), 1 = DOWN (+y), 2 = LEFT (−x), 3 = UP (−y).
- On a clock edge with start=1:
  - head = (START_X, START_Y);
  - dir = RIGHT;
  - len = 2;
  - seg0 = (START_X−1, START_Y), seg1 = (START_X−2, START_Y);
  - seg2..seg4 = 40'hFF_FFFF_FFFF (invalid sentinel).
- Outputs are registered and reflect the reset values from the cycle after the reset edge.
- Invalid segments (index ≥ len) always drive all-ones.
- With start=0 and update=0: all state holds. rotL, rotR and grow are ignored.
- With start=0 and update=1, everything below resolves in a single edge (one-cycle latency):
  1. New heading: rotR only → dir+1 mod 4; rotL only → dir−1 mod 4; both or neither → unchanged.
  2. Head moves one cell in the new heading, with toroidal wrap:
     - x = GRID_W−1 moving RIGHT → 0;
     - x = 0 moving LEFT → GRID_W−1;
     - y = GRID_H−1 moving DOWN → 0;
     - y = 0 moving UP → GRID_H−1.
  3. Body shifts: seg0 ← old head; seg[i] ← old seg[i−1] for 1 ≤ i < len.
  4. Growth:
     - grow=1 and len<5: len ← len+1, and seg[old len] ← old seg[len−1], i.e. the tail is preserved.
     - grow=1 and len=5: ignored; the tail drops as normal.
     - grow=0: len unchanged; the old tail drops.
- Rotation is applied before the move in the same cycle; a held rotL/rotR turns once per update cycle.
- No self-collision detection; downstream logic compares head against body.
- Coordinate arithmetic is modular within the grid. Upper unused bits of x/y are always 0 for valid cells.
- start asserted mid-game fully re-initialises on that edge, regardless of update, rotL, rotR or grow.

Test Plan:
1. Reset + continuous grow: start=1 for one edge, then start=0, update=1, grow=1, rot=0.
   - After 1st move: head=(33,24), seg0=(32,24), seg1=(31,24), seg2=(30,24), seg3/seg4 all-ones.
   - After 3 moves: len=5, head=(35,24), seg4=(30,24).
   - After 4th move: len stays 5, head=(36,24), seg4=(31,24).
2. Hold: update=0 with rotL=rotR=grow=1 for 5 cycles → head, body and dir unchanged from the post-reset values.
3. Rotation: from reset, update=1, rotR=1 for one cycle → head=(32,25) (DOWN). Then rotL=1 for one cycle → head=(33,25) (RIGHT). rotL=rotR=1 → heading unchanged.
4. Wrap: from reset, 31 plain moves right reach x=63; the next move → head x=0, y=24. Separately, turn UP and move from y=0 → y=47.
5. Mid-game reset: after 7 moves with turns and growth, assert start with update=1, grow=1 → next outputs exactly equal the post-reset values (head (32,24), len 2, RIGHT).
6. Fixed length: grow=0, update=1 for 3 cycles from reset → len stays 2, head=(35,24), seg0=(34,24), seg1=(33,24), seg2..4 all-ones.

Source files
------------

// File: rtl/snake.sv
// Snake position engine: head coordinate, up to five trailing body segments and heading,
// advanced one grid cell per update tick with toroidal wrap, rotation and growth.
module snake #(
    parameter int GRID_W  = 64,
    parameter int GRID_H  = 48,
    parameter int START_X = 32,
    parameter int START_Y = 24
) (
    input  logic         clk,
    input  logic         start,
    input  logic         update,
    input  logic         rotL,
    input  logic         rotR,
    input  logic         grow,
    output logic [39:0]  head,
    output logic [199:0] body
);

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    localparam logic [19:0] X_MAX    = 20'(GRID_W - 1);
    localparam logic [19:0] Y_MAX    = 20'(GRID_H - 1);
    localparam logic [19:0] X_START  = 20'(START_X);
    localparam logic [19:0] Y_START  = 20'(START_Y);
    localparam logic [39:0] SENTINEL = 40'hFF_FFFF_FFFF;
    localparam logic [2:0]  LEN_MAX  = 3'd5;
    localparam logic [2:0]  LEN_INIT = 3'd2;

    dir_t        dir_r,    dir_nxt_s,  dir_mv_s;
    logic [19:0] head_x_r, head_x_nxt_s, x_mv_s;
    logic [19:0] head_y_r, head_y_nxt_s, y_mv_s;
    logic [2:0]  len_r,    len_nxt_s,  len_mv_s;
    logic [39:0] seg_r     [5];
    logic [39:0] seg_nxt_s [5];
    logic [39:0] seg_mv_s  [5];

    // Candidate state for a move: rotate first, then step the head and shift the body.
    always_comb begin
        dir_mv_s = dir_r;
        x_mv_s   = head_x_r;
        y_mv_s   = head_y_r;
        len_mv_s = len_r;

        if (rotR && !rotL) begin
            dir_mv_s = dir_t'(dir_r + 2'd1);
        end else if (rotL && !rotR) begin
            dir_mv_s = dir_t'(dir_r - 2'd1);
        end else begin
            dir_mv_s = dir_r;
        end

        case (dir_mv_s)
            DIR_RIGHT: x_mv_s = (head_x_r == X_MAX) ? 20'd0 : head_x_r + 20'd1;
            DIR_LEFT:  x_mv_s = (head_x_r == 20'd0) ? X_MAX : head_x_r - 20'd1;
            DIR_DOWN:  y_mv_s = (head_y_r == Y_MAX) ? 20'd0 : head_y_r + 20'd1;
            DIR_UP:    y_mv_s = (head_y_r == 20'd0) ? Y_MAX : head_y_r - 20'd1;
            default: begin
                x_mv_s = head_x_r;
                y_mv_s = head_y_r;
            end
        endcase

        if (grow && (len_r < LEN_MAX)) begin
            len_mv_s = len_r + 3'd1;
        end else begin
            len_mv_s = len_r;
        end

        // Growing extends the valid range by one, so the old tail survives in seg[old len].
        seg_mv_s[0] = (len_mv_s > 3'd0) ? {head_x_r, head_y_r} : SENTINEL;
        for (int i = 1; i < 5; i++) begin
            seg_mv_s[i] = (3'(i) < len_mv_s) ? seg_r[i-1] : SENTINEL;
        end
    end

    // Next-state select: restart beats move, move beats hold.
    always_comb begin
        dir_nxt_s    = dir_r;
        head_x_nxt_s = head_x_r;
        head_y_nxt_s = head_y_r;
        len_nxt_s    = len_r;
        for (int i = 0; i < 5; i++) begin
            seg_nxt_s[i] = seg_r[i];
        end

        if (start) begin
            dir_nxt_s    = DIR_RIGHT;
            head_x_nxt_s = X_START;
            head_y_nxt_s = Y_START;
            len_nxt_s    = LEN_INIT;
            seg_nxt_s[0] = {X_START - 20'd1, Y_START};
            seg_nxt_s[1] = {X_START - 20'd2, Y_START};
            seg_nxt_s[2] = SENTINEL;
            seg_nxt_s[3] = SENTINEL;
            seg_nxt_s[4] = SENTINEL;
        end else if (update) begin
            dir_nxt_s    = dir_mv_s;
            head_x_nxt_s = x_mv_s;
            head_y_nxt_s = y_mv_s;
            len_nxt_s    = len_mv_s;
            for (int i = 0; i < 5; i++) begin
                seg_nxt_s[i] = seg_mv_s[i];
            end
        end else begin
            dir_nxt_s = dir_r;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        dir_r    <= dir_nxt_s;
        head_x_r <= head_x_nxt_s;
        head_y_r <= head_y_nxt_s;
        len_r    <= len_nxt_s;
        for (int i = 0; i < 5; i++) begin
            seg_r[i] <= seg_nxt_s[i];
        end
    end

    // Flatten registered state onto the output buses.
    always_comb begin
        head = {head_x_r, head_y_r};
        body = {seg_r[4], seg_r[3], seg_r[2], seg_r[1], seg_r[0]};
    end

endmodule

// File: tb/tb_snake.sv
// Directed self-checking bench for snake: reset, growth, hold, rotation, wrap and restart.
module tb_snake;

    logic         clk = 1'b0;
    logic         start = 1'b0;
    logic         update = 1'b0;
    logic         rotL = 1'b0;
    logic         rotR = 1'b0;
    logic         grow = 1'b0;
    logic [39:0]  head;
    logic [199:0] body;

    int checks_cnt = 0;
    int errors_cnt = 0;

    localparam logic [39:0] ONES = 40'hFF_FFFF_FFFF;

    snake dut (
        .clk    (clk),
        .start  (start),
        .update (update),
        .rotL   (rotL),
        .rotR   (rotR),
        .grow   (grow),
        .head   (head),
        .body   (body)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] xy(input int x, input int y);
        return {20'(x), 20'(y)};
    endfunction

    function automatic logic [39:0] seg(input int i);
        return body[40*i +: 40];
    endfunction

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Apply inputs for one rising edge, then settle past the edge before returning.
    task automatic step(input logic s, input logic u, input logic l, input logic r, input logic g);
        start  = s;
        update = u;
        rotL   = l;
        rotR   = r;
        grow   = g;
        @(posedge clk);
        #1;
        start  = 1'b0;
        update = 1'b0;
        rotL   = 1'b0;
        rotR   = 1'b0;
        grow   = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_head"}, head,   xy(32, 24));
        check({tag, "_seg0"}, seg(0), xy(31, 24));
        check({tag, "_seg1"}, seg(1), xy(30, 24));
        check({tag, "_seg2"}, seg(2), ONES);
        check({tag, "_seg3"}, seg(3), ONES);
        check({tag, "_seg4"}, seg(4), ONES);
    endtask

    initial begin
        #2;
        // 1: reset then continuous growth
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_reset_state("rst");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("g1_head", head,   xy(33, 24));
        check("g1_seg0", seg(0), xy(32, 24));
        check("g1_seg1", seg(1), xy(31, 24));
        check("g1_seg2", seg(2), xy(30, 24));
        check("g1_seg3", seg(3), ONES);
        check("g1_seg4", seg(4), ONES);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("g2_seg3", seg(3), xy(30, 24));
        check("g2_seg4", seg(4), ONES);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("g3_head", head,   xy(35, 24));
        check("g3_seg0", seg(0), xy(34, 24));
        check("g3_seg4", seg(4), xy(30, 24));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("g4_head", head,   xy(36, 24));
        check("g4_seg3", seg(3), xy(32, 24));
        check("g4_seg4", seg(4), xy(31, 24));

        // 2: hold ignores rotation and growth
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        end
        check_reset_state("hold");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hold_dir", head, xy(33, 24));
        check("hold_len", seg(2), ONES);

        // 3: rotation
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("rotR_head", head,   xy(32, 25));
        check("rotR_seg0", seg(0), xy(32, 24));
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("rotL_head", head, xy(33, 25));
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rotLR_head", head,   xy(34, 25));
        check("rotLR_seg0", seg(0), xy(33, 25));
        check("rotLR_seg1", seg(1), xy(32, 25));

        // 4: wrap right edge, then top edge
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 31; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("wrapx_pre", head, xy(63, 24));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("wrapx_head", head,   xy(0, 24));
        check("wrapx_seg0", seg(0), xy(63, 24));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("up_head", head, xy(32, 23));
        for (int i = 0; i < 23; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("wrapy_pre", head, xy(32, 0));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("wrapy_head", head,   xy(32, 47));
        check("wrapy_seg0", seg(0), xy(32, 0));

        // 5: mid-game restart
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check_reset_state("restart");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("restart_mv_head", head,   xy(33, 24));
        check("restart_mv_seg1", seg(1), xy(31, 24));
        check("restart_mv_seg2", seg(2), ONES);

        // 6: fixed length
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("fix_head", head,   xy(35, 24));
        check("fix_seg0", seg(0), xy(34, 24));
        check("fix_seg1", seg(1), xy(33, 24));
        check("fix_seg2", seg(2), ONES);
        check("fix_seg3", seg(3), ONES);
        check("fix_seg4", seg(4), ONES);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
